// File: rtl/haraka_ser_pkg.sv
// Shared types and configuration helpers for the Haraka-S wide-to-narrow serializers.
package haraka_ser_pkg;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ser_state_t;

   function automatic int beats(input int inwidth, input int outwidth);
      return inwidth / outwidth;
   endfunction

   function automatic bit width_ok(input int inwidth, input int outwidth);
      return (outwidth > 0) && ((inwidth % outwidth) == 0) && ((inwidth / outwidth) >= 2);
   endfunction

   function automatic int src_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/serializer_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after ptr_i, so the
// last-served requester has the lowest priority.
module rr_arbiter
   import haraka_ser_pkg::*;
#(
   parameter int NREQ = 2,
   localparam int SRCW = src_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [SRCW-1:0] ptr_i,
   output logic [NREQ-1:0] grant_onehot_o,
   output logic [SRCW-1:0] grant_idx_o,
   output logic            any_o
);

   // Rotating priority scan: the first valid requester after ptr_i wins.
   always_comb begin
      logic [SRCW-1:0] idx_s;
      logic            hit_s;
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      any_o          = 1'b0;
      idx_s          = '0;
      hit_s          = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s                 = SRCW'((int'(ptr_i) + k) % NREQ);
         hit_s                 = req_i[idx_s] & ~any_o;
         grant_onehot_o[idx_s] = grant_onehot_o[idx_s] | hit_s;
         grant_idx_o           = hit_s ? idx_s : grant_idx_o;
         any_o                 = any_o | hit_s;
      end
   end

endmodule

// File: rtl/serializer_arbiter.sv
// Shares one INWIDTH-to-OUTWIDTH serializer between NREQ producers; each granted word
// is sent LSB chunk first as a valid/ready beat stream tagged with its source.
module serializer_arbiter
   import haraka_ser_pkg::*;
#(
   parameter int INWIDTH  = 256,
   parameter int OUTWIDTH = 64,
   parameter int NREQ     = 2,
   localparam int SRCW    = src_width(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*INWIDTH-1:0] req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic                    out_valid,
   output logic [OUTWIDTH-1:0]     out_data,
   output logic                    out_last,
   output logic [SRCW-1:0]         out_src,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int BEATS = beats(INWIDTH, OUTWIDTH);
   localparam int CNTW  = $clog2(BEATS);
   localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

   if (!width_ok(INWIDTH, OUTWIDTH)) begin : g_bad_cfg
      $error("serializer_arbiter: INWIDTH must be a multiple (>=2x) of OUTWIDTH");
   end

   ser_state_t          state_q, state_d;
   logic [INWIDTH-1:0]  shreg_q, shreg_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic [SRCW-1:0]     src_q, src_d;
   logic [SRCW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]     grant_s;
   logic [SRCW-1:0]     grant_idx_s;
   logic                grant_any_s;
   logic [NREQ-1:0]     req_ready_s;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req_i          (req_valid),
      .ptr_i          (ptr_q),
      .grant_onehot_o (grant_s),
      .grant_idx_o    (grant_idx_s),
      .any_o          (grant_any_s)
   );

   // State and datapath registers; reset abandons any partially sent word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         src_q   <= '0;
         ptr_q   <= SRCW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic: accept in IDLE, shift out one chunk per accepted beat in SEND.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      src_d       = src_q;
      ptr_d       = ptr_q;
      req_ready_s = '0;
      case (state_q)
         IDLE: begin
            req_ready_s = grant_s;
            if (grant_any_s) begin
               shreg_d = req_data[grant_idx_s * INWIDTH +: INWIDTH];
               src_d   = grant_idx_s;
               ptr_d   = grant_idx_s;
               cnt_d   = '0;
               state_d = SEND;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (out_ready) begin
               shreg_d = shreg_q >> OUTWIDTH;
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req_ready = req_ready_s;
   assign out_valid = (state_q == SEND);
   assign out_data  = shreg_q[OUTWIDTH-1:0];
   assign out_last  = (state_q == SEND) && (cnt_q == LAST_BEAT);
   assign out_src   = src_q;
   assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed and scoreboard-checked bench for serializer_arbiter (NREQ=2 x 256->64, NREQ=1 x 256->128).
module tb_serializer_arbiter;

   localparam logic [255:0] WA = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
   localparam logic [255:0] WB = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
   localparam logic [127:0] WC_LO = {32{4'h5}};
   localparam logic [127:0] WC_HI = {32{4'hC}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   v0 = 2'b00;
   logic [511:0] d0 = '0;
   logic [1:0]   rdy0;
   logic         ov0, olast0, osrc0, ordy0 = 1'b1, busy0;
   logic [63:0]  odata0;
   logic [0:0]   v1 = 1'b0;
   logic [255:0] d1 = '0;
   logic [0:0]   rdy1;
   logic         ov1, olast1, ordy1 = 1'b1, busy1;
   logic [0:0]   osrc1;
   logic [127:0] odata1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serializer_arbiter #(.INWIDTH(256), .OUTWIDTH(64), .NREQ(2)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_data(d0), .req_ready(rdy0),
      .out_valid(ov0), .out_data(odata0), .out_last(olast0), .out_src(osrc0),
      .out_ready(ordy0), .busy(busy0)
   );

   serializer_arbiter #(.INWIDTH(256), .OUTWIDTH(128), .NREQ(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1), .req_ready(rdy1),
      .out_valid(ov1), .out_data(odata1), .out_last(olast1), .out_src(osrc1),
      .out_ready(ordy1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] lane(input logic [255:0] w, input int k);
      return w[k*64 +: 64];
   endfunction

   task automatic do_reset();
      rst   = 1'b1;
      v0    = 2'b00;
      v1    = 1'b0;
      ordy0 = 1'b1;
      ordy1 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int           ltab[7];
      logic         rtab[7];
      logic [1:0]   hold;
      logic         m_busy;
      int           m_cnt;
      int           m_ptr;
      int           m_src;
      logic [255:0] m_word;
      logic [1:0]   exp_rdy;
      int           g;
      ltab = '{0, 1, 1, 1, 1, 2, 3};
      rtab = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // reset state
      do_reset();
      #1;
      chk("rst_valid", ov0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_ready", rdy0, 2'b00);
      chk("rst_data", odata0, 64'h0);
      chk("rst_last", olast0, 1'b0);
      chk("rst_src", osrc0, 1'b0);

      // 1: single word, full throughput
      d0 = {WB, WA};
      v0 = 2'b01;
      #1 chk("t1_ready", rdy0, 2'b01);
      @(negedge clk);
      v0 = 2'b00;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t1_valid", ov0, 1'b1);
         chk("t1_data", odata0, lane(WA, k));
         chk("t1_last", olast0, (k == 3));
         chk("t1_src", osrc0, 1'b0);
         @(negedge clk);
      end
      #1;
      chk("t1_idle_valid", ov0, 1'b0);
      chk("t1_idle_busy", busy0, 1'b0);

      // 2: both continuously valid -> 0,1,0,1 at 5 cycles/word
      do_reset();
      v0 = 2'b11;
      for (int c = 0; c < 20; c++) begin
         #1;
         chk("t2_ready", rdy0, (c % 5 == 0) ? (((c / 5) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
         if (c % 5 != 0) begin
            chk("t2_src", osrc0, (c / 5) % 2);
            chk("t2_data", odata0, lane(((c / 5) % 2 == 0) ? WA : WB, (c % 5) - 1));
         end
         @(negedge clk);
      end
      v0 = 2'b00;

      // 3: backpressure for 3 cycles on beat 1
      do_reset();
      v0 = 2'b01;
      #1 chk("t3_ready", rdy0, 2'b01);
      @(negedge clk);
      v0 = 2'b00;
      for (int i = 0; i < 7; i++) begin
         ordy0 = rtab[i];
         #1;
         chk("t3_valid", ov0, 1'b1);
         chk("t3_data", odata0, lane(WA, ltab[i]));
         chk("t3_last", olast0, (ltab[i] == 3));
         @(negedge clk);
      end
      ordy0 = 1'b1;
      #1 chk("t3_end_valid", ov0, 1'b0);

      // 4a: reset during beat 2, then req1 alone
      do_reset();
      v0 = 2'b01;
      @(negedge clk);
      v0 = 2'b00;
      @(negedge clk);
      @(negedge clk);
      #1 chk("t4_beat2", odata0, lane(WA, 2));
      rst = 1'b1;
      #1;
      chk("t4_rst_valid", ov0, 1'b0);
      chk("t4_rst_busy", busy0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      v0  = 2'b10;
      #1 chk("t4_ready1", rdy0, 2'b10);
      @(negedge clk);
      v0 = 2'b00;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t4_data", odata0, lane(WB, k));
         chk("t4_src", osrc0, 1'b1);
         chk("t4_last", olast0, (k == 3));
         @(negedge clk);
      end
      // 4b: pointer restarts after a reset that follows serving req0
      do_reset();
      v0 = 2'b01;
      @(negedge clk);
      v0 = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      v0  = 2'b11;
      #1 chk("t4_rr_restart", rdy0, 2'b01);
      @(negedge clk);
      v0 = 2'b00;

      // 5: req1 pulses valid while busy, then withdraws
      do_reset();
      v0 = 2'b01;
      @(negedge clk);
      v0 = 2'b10;
      #1 chk("t5_no_ready", rdy0, 2'b00);
      @(negedge clk);
      v0 = 2'b00;
      for (int k = 1; k < 4; k++) begin
         #1;
         chk("t5_data", odata0, lane(WA, k));
         chk("t5_src", osrc0, 1'b0);
         @(negedge clk);
      end
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5_quiet_valid", ov0, 1'b0);
         chk("t5_quiet_busy", busy0, 1'b0);
         @(negedge clk);
      end

      // 5b: random soak against a reference model
      do_reset();
      hold   = 2'b00;
      m_busy = 1'b0;
      m_cnt  = 0;
      m_ptr  = 1;
      m_src  = 0;
      m_word = '0;
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!hold[i]) begin
               v0[i] = ($urandom_range(0, 2) == 0);
               d0[i*256 +: 256] = {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};
               hold[i] = v0[i];
            end
         end
         ordy0 = ($urandom_range(0, 3) != 0);
         #1;
         exp_rdy = 2'b00;
         g = -1;
         if (!m_busy) begin
            if (v0[(m_ptr + 1) % 2]) g = (m_ptr + 1) % 2;
            else if (v0[m_ptr]) g = m_ptr;
            if (g >= 0) exp_rdy[g] = 1'b1;
         end
         chk("soak_ready", rdy0, exp_rdy);
         chk("soak_valid", ov0, m_busy);
         if (m_busy) begin
            chk("soak_data", odata0, lane(m_word, m_cnt));
            chk("soak_last", olast0, (m_cnt == 3));
            chk("soak_src", osrc0, m_src);
         end
         if (!m_busy && g >= 0) begin
            m_busy  = 1'b1;
            m_word  = d0[g*256 +: 256];
            m_src   = g;
            m_ptr   = g;
            m_cnt   = 0;
            hold[g] = 1'b0;
         end else if (m_busy && ordy0) begin
            m_cnt++;
            if (m_cnt == 4) begin
               m_busy = 1'b0;
               m_cnt  = 0;
            end
         end
         @(negedge clk);
      end
      v0 = 2'b00;

      // 6: NREQ=1, 128-bit beats, 3 cycles/word
      do_reset();
      d1 = {WC_HI, WC_LO};
      v1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("t6_ready", rdy1, (c % 3 == 0));
         chk("t6_valid", ov1, (c % 3 != 0));
         if (c % 3 != 0) begin
            chk("t6_data", odata1, (c % 3 == 1) ? WC_LO : WC_HI);
            chk("t6_last", olast1, (c % 3 == 2));
            chk("t6_src", osrc1, 1'b0);
         end
         @(negedge clk);
      end
      v1 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
